// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller signal bundle: hazard sources in, stall/flush/redirect and perf counters out.
interface hazard_controller_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    logic                      ic_busy;
    logic                      dc_miss;
    logic                      ds_valid;
    logic                      ds_uses_rs;
    logic [REG_ADDR_WIDTH-1:0] ds_rs_addr;
    logic                      ds_uses_rt;
    logic [REG_ADDR_WIDTH-1:0] ds_rt_addr;
    logic                      ex_is_load;
    logic [REG_ADDR_WIDTH-1:0] ex_rw_addr;
    logic                      br_valid;
    logic                      br_mispredict;
    logic [ADDR_WIDTH-1:0]     br_target;

    logic                      if_stall;
    logic                      i2d_stall, i2d_flush;
    logic                      d2e_stall, d2e_flush;
    logic                      e2m_stall, e2m_flush;
    logic                      m2w_stall, m2w_flush;
    logic                      redirect_valid;
    logic [ADDR_WIDTH-1:0]     redirect_pc;
    logic [CNT_WIDTH-1:0]      cnt_loaduse, cnt_mispredict, cnt_dc_miss, cnt_ic_busy;

    // Pipeline side.
    modport master (
        output ic_busy, dc_miss, ds_valid, ds_uses_rs, ds_rs_addr, ds_uses_rt, ds_rt_addr,
               ex_is_load, ex_rw_addr, br_valid, br_mispredict, br_target,
        input  if_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush, e2m_stall, e2m_flush,
               m2w_stall, m2w_flush, redirect_valid, redirect_pc,
               cnt_loaduse, cnt_mispredict, cnt_dc_miss, cnt_ic_busy
    );

    // Hazard controller side.
    modport slave (
        input  ic_busy, dc_miss, ds_valid, ds_uses_rs, ds_rs_addr, ds_uses_rt, ds_rt_addr,
               ex_is_load, ex_rw_addr, br_valid, br_mispredict, br_target,
        output if_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush, e2m_stall, e2m_flush,
               m2w_stall, m2w_flush, redirect_valid, redirect_pc,
               cnt_loaduse, cnt_mispredict, cnt_dc_miss, cnt_ic_busy
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline stall/flush/redirect generation with a pending-redirect FSM for a busy I-cache.
// Optional saturating perf counters enabled by defining HC_PERF_CNT_EN.
module hazard_controller #(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input logic                clk,
    input logic                rst_n,
    hazard_controller_if.slave hc
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] pend_pc, pend_pc_nxt;
    logic                  load_use, mispredict;
    logic                  if_stall_c, i2d_stall_c, i2d_flush_c, d2e_stall_c, d2e_flush_c;
    logic                  e2m_stall_c, e2m_flush_c, m2w_stall_c, m2w_flush_c;

    assign load_use = hc.ds_valid && hc.ex_is_load &&
                      (hc.ex_rw_addr != {REG_ADDR_WIDTH{1'b0}}) &&
                      ((hc.ds_uses_rs && (hc.ds_rs_addr == hc.ex_rw_addr)) ||
                       (hc.ds_uses_rt && (hc.ds_rt_addr == hc.ex_rw_addr)));
    assign mispredict = hc.br_valid && hc.br_mispredict;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_nxt         = state;
        pend_pc_nxt       = pend_pc;
        if_stall_c        = 1'b0;
        i2d_stall_c       = 1'b0;
        i2d_flush_c       = 1'b0;
        d2e_stall_c       = 1'b0;
        d2e_flush_c       = 1'b0;
        e2m_stall_c       = 1'b0;
        e2m_flush_c       = 1'b0;
        m2w_stall_c       = 1'b0;
        m2w_flush_c       = 1'b0;
        hc.redirect_valid = 1'b0;
        hc.redirect_pc    = '0;

        // NOTE: the synchronous reset lives in the next-state logic so the reset cycle also drives flush outputs.
        if (!rst_n) begin
            if_stall_c  = 1'b1;
            i2d_flush_c = 1'b1;
            d2e_flush_c = 1'b1;
            e2m_flush_c = 1'b1;
            m2w_flush_c = 1'b1;
            state_nxt   = IDLE;
            pend_pc_nxt = '0;
        end else if (hc.dc_miss) begin
            // Freeze everything up to MEM; a branch in EX is re-presented once the miss clears.
            if_stall_c  = 1'b1;
            i2d_stall_c = 1'b1;
            d2e_stall_c = 1'b1;
            e2m_stall_c = 1'b1;
            m2w_flush_c = 1'b1;
        end else if (state == IDLE && mispredict) begin
            i2d_flush_c = 1'b1;
            d2e_flush_c = 1'b1;
            if (hc.ic_busy) begin
                if_stall_c  = 1'b1;
                pend_pc_nxt = hc.br_target;
                state_nxt   = WAIT;
            end else begin
                hc.redirect_valid = 1'b1;
                hc.redirect_pc    = hc.br_target;
            end
        end else if (state == WAIT) begin
            i2d_flush_c    = 1'b1;
            hc.redirect_pc = pend_pc;
            if (hc.ic_busy) begin
                if_stall_c = 1'b1;
            end else begin
                hc.redirect_valid = 1'b1;
                state_nxt         = IDLE;
            end
        end else if (load_use) begin
            if_stall_c  = 1'b1;
            i2d_stall_c = 1'b1;
            d2e_flush_c = 1'b1;
        end else if (hc.ic_busy) begin
            if_stall_c  = 1'b1;
            i2d_flush_c = 1'b1;
        end
    end

    // Stall wins over flush at every pipeline register.
    assign hc.if_stall  = if_stall_c;
    assign hc.i2d_stall = i2d_stall_c;
    assign hc.i2d_flush = i2d_flush_c & ~i2d_stall_c;
    assign hc.d2e_stall = d2e_stall_c;
    assign hc.d2e_flush = d2e_flush_c & ~d2e_stall_c;
    assign hc.e2m_stall = e2m_stall_c;
    assign hc.e2m_flush = e2m_flush_c & ~e2m_stall_c;
    assign hc.m2w_stall = m2w_stall_c;
    assign hc.m2w_flush = m2w_flush_c & ~m2w_stall_c;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        state   <= state_nxt;
        pend_pc <= pend_pc_nxt;
    end

    // EX only holds bubbles while a redirect is pending, so no new mispredict can resolve.
    a_no_mispredict_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        !(state == WAIT && mispredict));

`ifdef HC_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_lu, cnt_mp, cnt_dc, cnt_ic;
    logic                 lu_en, mp_en;

    assign lu_en = rst_n && !hc.dc_miss && (state == IDLE) && !mispredict && load_use;
    assign mp_en = rst_n && !hc.dc_miss && (state == IDLE) && mispredict;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic en);
        return (en && (c != {CNT_WIDTH{1'b1}})) ? c + CNT_WIDTH'(1) : c;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_lu <= '0;
            cnt_mp <= '0;
            cnt_dc <= '0;
            cnt_ic <= '0;
        end else begin
            cnt_lu <= sat_inc(cnt_lu, lu_en);
            cnt_mp <= sat_inc(cnt_mp, mp_en);
            cnt_dc <= sat_inc(cnt_dc, hc.dc_miss);
            cnt_ic <= sat_inc(cnt_ic, hc.ic_busy);
        end
    end

    assign hc.cnt_loaduse    = cnt_lu;
    assign hc.cnt_mispredict = cnt_mp;
    assign hc.cnt_dc_miss    = cnt_dc;
    assign hc.cnt_ic_busy    = cnt_ic;
`else
    assign hc.cnt_loaduse    = {CNT_WIDTH{1'b0}};
    assign hc.cnt_mispredict = {CNT_WIDTH{1'b0}};
    assign hc.cnt_dc_miss    = {CNT_WIDTH{1'b0}};
    assign hc.cnt_ic_busy    = {CNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed vector table, multi-cycle sequences, random vs. reference model.
// Counter expectations follow HC_PERF_CNT_EN.
module tb_hazard_controller;
    localparam int AW   = 32;
    localparam int RW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    // Control bit positions, MSB first: if_stall, i2d s/f, d2e s/f, e2m s/f, m2w s/f, redirect_valid.
    localparam logic [9:0] C_IF    = 10'h200, C_I2D_S = 10'h100, C_I2D_F = 10'h080;
    localparam logic [9:0] C_D2E_S = 10'h040, C_D2E_F = 10'h020, C_E2M_S = 10'h010;
    localparam logic [9:0] C_E2M_F = 10'h008, C_M2W_F = 10'h002, C_RV    = 10'h001;
    localparam logic [9:0] RST_CTL = C_IF | C_I2D_F | C_D2E_F | C_E2M_F | C_M2W_F;
    localparam logic [9:0] DC_CTL  = C_IF | C_I2D_S | C_D2E_S | C_E2M_S | C_M2W_F;
    localparam logic [9:0] LU_CTL  = C_IF | C_I2D_S | C_D2E_F;

    typedef struct packed {
        logic          ic_busy, dc_miss, ds_valid, ds_uses_rs;
        logic [RW-1:0] rs;
        logic          ds_uses_rt;
        logic [RW-1:0] rt;
        logic          ex_is_load;
        logic [RW-1:0] rw;
        logic          br_valid, br_mispredict;
        logic [AW-1:0] tgt;
    } in_t;

    typedef struct {
        string       name;
        in_t         in;
        logic [9:0]  ctl;
        logic [31:0] pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    hazard_controller_if #(.ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) hc_if ();

    hazard_controller #(.ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hc   (hc_if)
    );

    always #5 clk = ~clk;

    // Reference model state: is a redirect pending, and where to.
    bit          m_wait;
    logic [31:0] m_pc;
    int          m_cnt_lu, m_cnt_mp, m_cnt_dc, m_cnt_ic;

    function automatic in_t mk_in(logic ic, logic dc, logic dv, logic urs, logic [RW-1:0] rs,
                                  logic urt, logic [RW-1:0] rt, logic ld, logic [RW-1:0] rw,
                                  logic bv, logic bm, logic [AW-1:0] tgt);
        in_t i;
        i.ic_busy = ic;  i.dc_miss = dc;  i.ds_valid = dv;  i.ds_uses_rs = urs;  i.rs = rs;
        i.ds_uses_rt = urt;  i.rt = rt;  i.ex_is_load = ld;  i.rw = rw;
        i.br_valid = bv;  i.br_mispredict = bm;  i.tgt = tgt;
        return i;
    endfunction

    function automatic bit hazard(in_t i);
        if (!(i.ds_valid && i.ex_is_load) || i.rw == 0) return 1'b0;
        return (i.ds_uses_rs && i.rs == i.rw) || (i.ds_uses_rt && i.rt == i.rw);
    endfunction

    function automatic logic [41:0] model_out(in_t i, logic rst);
        logic [9:0]  c;
        logic [31:0] pc;
        c  = '0;
        pc = '0;
        if (!rst)                                c = RST_CTL;
        else if (i.dc_miss)                      c = DC_CTL;
        else if (m_wait) begin
            c  = C_I2D_F | (i.ic_busy ? C_IF : C_RV);
            pc = m_pc;
        end else if (i.br_valid && i.br_mispredict) begin
            c  = C_I2D_F | C_D2E_F | (i.ic_busy ? C_IF : C_RV);
            pc = i.ic_busy ? 32'h0 : i.tgt;
        end else if (hazard(i))                  c = LU_CTL;
        else if (i.ic_busy)                      c = C_IF | C_I2D_F;
        return {c, pc};
    endfunction

    function automatic int sat(int x);
        return (x < CMAX) ? x + 1 : x;
    endfunction

    task automatic model_advance(in_t i, logic rst);
        if (!rst) begin
            m_wait = 0;  m_pc = '0;
            m_cnt_lu = 0;  m_cnt_mp = 0;  m_cnt_dc = 0;  m_cnt_ic = 0;
            return;
        end
        if (!i.dc_miss) begin
            if (m_wait) begin
                if (!i.ic_busy) m_wait = 0;
            end else if (i.br_valid && i.br_mispredict) begin
                m_cnt_mp = sat(m_cnt_mp);
                if (i.ic_busy) begin
                    m_wait = 1;
                    m_pc   = i.tgt;
                end
            end else if (hazard(i)) begin
                m_cnt_lu = sat(m_cnt_lu);
            end
        end
        if (i.dc_miss) m_cnt_dc = sat(m_cnt_dc);
        if (i.ic_busy) m_cnt_ic = sat(m_cnt_ic);
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic apply(in_t i);
        hc_if.ic_busy       = i.ic_busy;
        hc_if.dc_miss       = i.dc_miss;
        hc_if.ds_valid      = i.ds_valid;
        hc_if.ds_uses_rs    = i.ds_uses_rs;
        hc_if.ds_rs_addr    = i.rs;
        hc_if.ds_uses_rt    = i.ds_uses_rt;
        hc_if.ds_rt_addr    = i.rt;
        hc_if.ex_is_load    = i.ex_is_load;
        hc_if.ex_rw_addr    = i.rw;
        hc_if.br_valid      = i.br_valid;
        hc_if.br_mispredict = i.br_mispredict;
        hc_if.br_target     = i.tgt;
    endtask

    function automatic logic [41:0] dut_out();
        return {hc_if.if_stall, hc_if.i2d_stall, hc_if.i2d_flush, hc_if.d2e_stall, hc_if.d2e_flush,
                hc_if.e2m_stall, hc_if.e2m_flush, hc_if.m2w_stall, hc_if.m2w_flush,
                hc_if.redirect_valid, hc_if.redirect_pc};
    endfunction

    function automatic logic [15:0] dut_cnt();
        return {hc_if.cnt_loaduse, hc_if.cnt_mispredict, hc_if.cnt_dc_miss, hc_if.cnt_ic_busy};
    endfunction

    // One clock: drive inputs, compare at the falling edge, advance past the next rising edge.
    task automatic step(string name, in_t i, logic rst, logic [9:0] ctl, logic [31:0] pc);
        rst_n = rst;
        apply(i);
        @(negedge clk);
        check(name, 64'(dut_out()), 64'({ctl, pc}));
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[16];
    in_t  idle_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_in = '0;
        vecs[0]  = '{"idle",       mk_in(0,0,0,0,0,0,0,0,0,0,0,32'h0),        10'h0,               32'h0};
        vecs[1]  = '{"lu_rt",      mk_in(0,0,1,0,0,1,5,1,5,0,0,32'h0),        LU_CTL,              32'h0};
        vecs[2]  = '{"lu_r0",      mk_in(0,0,1,0,0,1,0,1,0,0,0,32'h0),        10'h0,               32'h0};
        vecs[3]  = '{"lu_rs",      mk_in(0,0,1,1,7,0,0,1,7,0,0,32'h0),        LU_CTL,              32'h0};
        vecs[4]  = '{"rs_unused",  mk_in(0,0,1,0,7,0,0,1,7,0,0,32'h0),        10'h0,               32'h0};
        vecs[5]  = '{"ds_invalid", mk_in(0,0,0,1,7,1,7,1,7,0,0,32'h0),        10'h0,               32'h0};
        vecs[6]  = '{"not_load",   mk_in(0,0,1,1,7,1,7,0,7,0,0,32'h0),        10'h0,               32'h0};
        vecs[7]  = '{"lu_icbusy",  mk_in(1,0,1,0,0,1,5,1,5,0,0,32'h0),        LU_CTL,              32'h0};
        vecs[8]  = '{"ic_busy",    mk_in(1,0,0,0,0,0,0,0,0,0,0,32'h0),        C_IF | C_I2D_F,      32'h0};
        vecs[9]  = '{"mp_redir",   mk_in(0,0,0,0,0,0,0,0,0,1,1,32'h0040_0100), C_I2D_F | C_D2E_F | C_RV, 32'h0040_0100};
        vecs[10] = '{"br_ok",      mk_in(0,0,1,0,0,1,5,0,0,1,0,32'h0040_0100), 10'h0,              32'h0};
        vecs[11] = '{"mp_over_lu", mk_in(0,0,1,0,0,1,5,1,5,1,1,32'h0040_0180), C_I2D_F | C_D2E_F | C_RV, 32'h0040_0180};
        vecs[12] = '{"dc_over_lu", mk_in(0,1,1,0,0,1,5,1,5,0,0,32'h0),        DC_CTL,              32'h0};
        vecs[13] = '{"dc_over_mp", mk_in(1,1,0,0,0,0,0,0,0,1,1,32'h0040_0100), DC_CTL,             32'h0};
        vecs[14] = '{"bm_no_bv",   mk_in(0,0,0,0,0,0,0,0,0,0,1,32'h0000_0123), 10'h0,              32'h0};
        vecs[15] = '{"rt_differ",  mk_in(0,0,1,0,0,1,6,1,5,0,0,32'h0),        10'h0,               32'h0};

        rst_n = 1'b0;
        apply(idle_in);
        @(posedge clk);
        #1;

        step("reset", idle_in, 1'b0, RST_CTL, 32'h0);
        step("post_reset", idle_in, 1'b1, 10'h0, 32'h0);

        foreach (vecs[k]) step(vecs[k].name, vecs[k].in, 1'b1, vecs[k].ctl, vecs[k].pc);

        // Redirect held while the I-cache is busy for three cycles.
        step("wait_accept", mk_in(1,0,0,0,0,0,0,0,0,1,1,32'h0040_0200), 1'b1, C_IF | C_I2D_F | C_D2E_F, 32'h0);
        step("wait_busy1", mk_in(1,0,0,0,0,0,0,0,0,0,0,32'h0), 1'b1, C_IF | C_I2D_F, 32'h0040_0200);
        step("wait_busy2", mk_in(1,0,0,0,0,0,0,0,0,0,0,32'h0), 1'b1, C_IF | C_I2D_F, 32'h0040_0200);
        step("wait_redir", idle_in, 1'b1, C_I2D_F | C_RV, 32'h0040_0200);
        step("wait_idle", idle_in, 1'b1, 10'h0, 32'h0);

        // D-cache miss holds the mispredicted branch; it redirects once the miss clears.
        step("dc_mp1", mk_in(0,1,0,0,0,0,0,0,0,1,1,32'h0040_0300), 1'b1, DC_CTL, 32'h0);
        step("dc_mp2", mk_in(0,1,0,0,0,0,0,0,0,1,1,32'h0040_0300), 1'b1, DC_CTL, 32'h0);
        step("dc_mp_redir", mk_in(0,0,0,0,0,0,0,0,0,1,1,32'h0040_0300), 1'b1, C_I2D_F | C_D2E_F | C_RV, 32'h0040_0300);
        step("dc_mp_idle", idle_in, 1'b1, 10'h0, 32'h0);

        // D-cache miss during WAIT keeps the pending target.
        step("wdc_accept", mk_in(1,0,0,0,0,0,0,0,0,1,1,32'h0040_0400), 1'b1, C_IF | C_I2D_F | C_D2E_F, 32'h0);
        step("wdc_miss", mk_in(1,1,0,0,0,0,0,0,0,0,0,32'h0), 1'b1, DC_CTL, 32'h0);
        step("wdc_redir", idle_in, 1'b1, C_I2D_F | C_RV, 32'h0040_0400);
        step("wdc_idle", idle_in, 1'b1, 10'h0, 32'h0);

        // Reset while waiting discards the pending redirect.
        step("wrst_accept", mk_in(1,0,0,0,0,0,0,0,0,1,1,32'h0040_0500), 1'b1, C_IF | C_I2D_F | C_D2E_F, 32'h0);
        step("wrst_reset", idle_in, 1'b0, RST_CTL, 32'h0);
        step("wrst_idle", idle_in, 1'b1, 10'h0, 32'h0);

        // Twenty D-cache miss cycles saturate a 4-bit counter.
        step("sat_reset", idle_in, 1'b0, RST_CTL, 32'h0);
        for (int n = 0; n < 20; n++)
            step("sat_dc", mk_in(0,1,0,0,0,0,0,0,0,0,0,32'h0), 1'b1, DC_CTL, 32'h0);
        @(negedge clk);
`ifdef HC_PERF_CNT_EN
        check("cnt_dc_sat", 64'(hc_if.cnt_dc_miss), 64'(CMAX));
`else
        check("cnt_dc_off", 64'(hc_if.cnt_dc_miss), 64'(0));
`endif
        @(posedge clk);
        #1;

        // Random traffic against the reference model, starting from a reset.
        m_wait = 0;
        for (int n = 0; n < 800; n++) begin
            in_t         ri;
            logic        rst;
            logic [41:0] exp;
            rst = (n == 0) || ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
            ri  = mk_in(1'($urandom_range(99) < 30), 1'($urandom_range(99) < 15),
                        1'($urandom_range(99) < 75), 1'($urandom), RW'($urandom_range(3)),
                        1'($urandom), RW'($urandom_range(3)), 1'($urandom),
                        RW'($urandom_range(3)), 1'($urandom_range(99) < 30),
                        1'($urandom), AW'($urandom));
            if (m_wait) ri.br_mispredict = 1'b0;
            exp = model_out(ri, rst);
            rst_n = rst;
            apply(ri);
            @(negedge clk);
            check("rand_out", 64'(dut_out()), 64'(exp));
`ifdef HC_PERF_CNT_EN
            check("rand_cnt", 64'(dut_cnt()),
                  64'({4'(m_cnt_lu), 4'(m_cnt_mp), 4'(m_cnt_dc), 4'(m_cnt_ic)}));
`else
            check("rand_cnt", 64'(dut_cnt()), 64'(0));
`endif
            @(posedge clk);
            #1;
            model_advance(ri, rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
